// File: rtl/matrix_inverse_nxn.sv
// N x N fixed-point matrix inverse: Gauss-Jordan elimination with partial pivoting, start/done handshake.
// Define MATINV_TIKHONOV_EN to load A + EPS*I instead of A (diagonal regularisation).
module matrix_inverse_nxn #(
   parameter int N        = 4,
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 16,
   parameter int GUARD_W  = 8,
   parameter int SING_THR = 2,
   parameter int EPS      = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [N-1:0][N-1:0][DATA_W-1:0] A,
   output logic [N-1:0][N-1:0][DATA_W-1:0] A_inv,
   output logic                            busy,
   output logic                            done,
   output logic                            singular,
   output logic                            overflow
);
   localparam int EXT_W = DATA_W + FRAC_W + GUARD_W;
   localparam int IDX_W = $clog2(N);
`ifdef MATINV_TIKHONOV_EN
   localparam bit TIK_EN = 1'b1;
`else
   localparam bit TIK_EN = 1'b0;
`endif
   localparam logic signed [EXT_W-1:0] DIAG_ADD = TIK_EN ? EXT_W'(EPS) : '0;
   localparam logic signed [EXT_W-1:0] ONE      = {{(EXT_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
   localparam logic signed [EXT_W-1:0] SAT_HI   = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_LO   = ~SAT_HI;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PIVOT, S_SCALE, S_ELIM, S_EXTRACT, S_DONE} state_t;

   state_t                          r_state;
   logic [IDX_W-1:0]                r_k;
   logic [IDX_W-1:0]                r_cnt;
   logic [N-1:0][N-1:0][DATA_W-1:0] r_a;
   logic signed [EXT_W-1:0]         r_aug [N][2*N];

   logic [IDX_W-1:0]                w_piv_row;
   logic [IDX_W-1:0]                w_row;
   logic [EXT_W:0]                  w_piv_mag;
   logic                            w_piv_low;
   logic [N-1:0][N-1:0][DATA_W-1:0] w_sat;
   logic                            w_ovf;

   function automatic logic [EXT_W:0] f_abs(input logic signed [EXT_W-1:0] x);
      logic signed [EXT_W:0] t;
      t = {x[EXT_W-1], x};
      return t[EXT_W] ? -t : t;
   endfunction

   // (num <<< FRAC_W) / piv, quotient truncates toward zero
   function automatic logic signed [EXT_W-1:0] f_div(input logic signed [EXT_W-1:0] num,
                                                     input logic signed [EXT_W-1:0] piv);
      logic signed [EXT_W+FRAC_W-1:0] n_ext;
      logic signed [EXT_W+FRAC_W-1:0] p_ext;
      logic signed [EXT_W+FRAC_W-1:0] q;
      n_ext = {{FRAC_W{num[EXT_W-1]}}, num} <<< FRAC_W;
      p_ext = {{FRAC_W{piv[EXT_W-1]}}, piv};
      q     = n_ext / p_ext;
      return q[EXT_W-1:0];
   endfunction

   function automatic logic signed [EXT_W-1:0] f_elim(input logic signed [EXT_W-1:0] a,
                                                      input logic signed [EXT_W-1:0] f,
                                                      input logic signed [EXT_W-1:0] p);
      logic signed [2*EXT_W-1:0] f_ext;
      logic signed [2*EXT_W-1:0] p_ext;
      logic signed [2*EXT_W-1:0] prod;
      f_ext = {{EXT_W{f[EXT_W-1]}}, f};
      p_ext = {{EXT_W{p[EXT_W-1]}}, p};
      prod  = (f_ext * p_ext) >>> FRAC_W;
      return a - prod[EXT_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] f_sat(input logic signed [EXT_W-1:0] x);
      if (x > SAT_HI)      return {1'b0, {(DATA_W-1){1'b1}}};
      else if (x < SAT_LO) return {1'b1, {(DATA_W-1){1'b0}}};
      return x[DATA_W-1:0];
   endfunction

   function automatic logic f_clip(input logic signed [EXT_W-1:0] x);
      return (x > SAT_HI) || (x < SAT_LO);
   endfunction

   // Strict '>' keeps the lowest row index on magnitude ties
   always_comb begin
      w_piv_row = r_k;
      w_piv_mag = f_abs(r_aug[r_k][r_k]);
      for (int r = 0; r < N; r++) begin
         if (r > int'(r_k) && f_abs(r_aug[r][r_k]) > w_piv_mag) begin
            w_piv_row = IDX_W'(r);
            w_piv_mag = f_abs(r_aug[r][r_k]);
         end
      end
      w_piv_low = (w_piv_mag < (EXT_W+1)'(SING_THR));
   end

   assign w_row = (r_cnt < r_k) ? r_cnt : r_cnt + IDX_W'(1);

   always_comb begin
      w_sat = '0;
      w_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w_sat[i][j] = f_sat(r_aug[i][N+j]);
            w_ovf       = w_ovf | f_clip(r_aug[i][N+j]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && start) r_a <= A;
      case (r_state)
         S_LOAD:
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  r_aug[i][j]   <= {{(EXT_W-DATA_W){r_a[i][j][DATA_W-1]}}, r_a[i][j]} + ((i == j) ? DIAG_ADD : '0);
                  r_aug[i][N+j] <= (i == j) ? ONE : '0;
               end
            end
         S_PIVOT:
            if (w_piv_row != r_k) begin
               for (int j = 0; j < 2*N; j++) begin
                  r_aug[r_k][j]       <= r_aug[w_piv_row][j];
                  r_aug[w_piv_row][j] <= r_aug[r_k][j];
               end
            end
         S_SCALE:
            for (int j = 0; j < 2*N; j++) r_aug[r_k][j] <= f_div(r_aug[r_k][j], r_aug[r_k][r_k]);
         S_ELIM:
            for (int j = 0; j < 2*N; j++) r_aug[w_row][j] <= f_elim(r_aug[w_row][j], r_aug[w_row][r_k], r_aug[r_k][j]);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         singular <= 1'b0;
         overflow <= 1'b0;
         A_inv    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy     <= 1'b1;
                  singular <= 1'b0;
                  overflow <= 1'b0;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_k     <= '0;
               r_state <= S_PIVOT;
            end
            S_PIVOT: begin
               // Abort routes through EXTRACT so done still lands two cycles after this pivot
               if (w_piv_low) begin
                  singular <= 1'b1;
                  A_inv    <= '0;
                  r_state  <= S_EXTRACT;
               end else begin
                  r_state  <= S_SCALE;
               end
            end
            S_SCALE: begin
               r_cnt   <= '0;
               r_state <= S_ELIM;
            end
            S_ELIM: begin
               if (r_cnt == IDX_W'(N-2)) begin
                  r_cnt <= '0;
                  if (r_k == IDX_W'(N-1)) begin
                     r_state <= S_EXTRACT;
                  end else begin
                     r_k     <= r_k + IDX_W'(1);
                     r_state <= S_PIVOT;
                  end
               end else begin
                  r_cnt <= r_cnt + IDX_W'(1);
               end
            end
            S_EXTRACT: begin
               if (!singular) begin
                  A_inv    <= w_sat;
                  overflow <= w_ovf;
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_DONE;
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_inverse_nxn.sv
// Bench for matrix_inverse_nxn: directed and random matrices checked against a Gauss-Jordan reference model.
module tb_matrix_inverse_nxn;
   localparam int N        = 4;
   localparam int DATA_W   = 32;
   localparam int FRAC_W   = 16;
   localparam int GUARD_W  = 8;
   localparam int SING_THR = 2;
   localparam int EXT_W    = DATA_W + FRAC_W + GUARD_W;

   typedef logic [N-1:0][N-1:0][DATA_W-1:0] mat_t;
   typedef logic signed [127:0] big_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   mat_t A     = '0;
   mat_t A_inv;
   logic busy, done, singular, overflow;

   int   n_chk  = 0;
   int   n_fail = 0;
   mat_t snap_inv;
   logic snap_sing, snap_ovf;
   int   snap_cyc;

   matrix_inverse_nxn #(.N(N), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .GUARD_W(GUARD_W),
                        .SING_THR(SING_THR), .EPS(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .A_inv(A_inv),
      .busy(busy), .done(done), .singular(singular), .overflow(overflow));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic big_t babs(input big_t x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic big_t wrap(input big_t x);
      logic signed [EXT_W-1:0] s;
      s = x[EXT_W-1:0];
      return big_t'(s);
   endfunction

   // Textbook Gauss-Jordan on [A | I] with the fixed-point rounding rules of the engine
   task automatic model(input mat_t m, output mat_t inv, output bit sing, output bit ovf, output int kab);
      big_t g [N][2*N];
      big_t piv, f, tmp, v, bmag, hi, lo;
      int   best;
      inv = '0; sing = 0; ovf = 0; kab = -1;
      hi  = (big_t'(1) <<< (DATA_W-1)) - 1;
      lo  = -(big_t'(1) <<< (DATA_W-1));
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            g[i][j]   = big_t'($signed(m[i][j]));
            g[i][N+j] = (i == j) ? (big_t'(1) <<< FRAC_W) : big_t'(0);
         end
      for (int k = 0; k < N; k++) begin
         best = k;
         bmag = babs(g[k][k]);
         for (int r = k + 1; r < N; r++)
            if (babs(g[r][k]) > bmag) begin best = r; bmag = babs(g[r][k]); end
         if (bmag < SING_THR) begin sing = 1; kab = k; return; end
         for (int j = 0; j < 2*N; j++) begin
            tmp = g[k][j]; g[k][j] = g[best][j]; g[best][j] = tmp;
         end
         piv = g[k][k];
         for (int j = 0; j < 2*N; j++) g[k][j] = wrap((g[k][j] <<< FRAC_W) / piv);
         for (int r = 0; r < N; r++)
            if (r != k) begin
               f = g[r][k];
               for (int j = 0; j < 2*N; j++) g[r][j] = wrap(g[r][j] - ((f * g[k][j]) >>> FRAC_W));
            end
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            v = g[i][N+j];
            if (v > hi)      begin inv[i][j] = {1'b0, {(DATA_W-1){1'b1}}}; ovf = 1; end
            else if (v < lo) begin inv[i][j] = {1'b1, {(DATA_W-1){1'b0}}}; ovf = 1; end
            else             inv[i][j] = v[DATA_W-1:0];
         end
   endtask

   task automatic run(input mat_t m, input string tag, input int restart_cyc);
      mat_t e_inv;
      bit   e_sing, e_ovf;
      int   kab, e_cyc, ndone, busy_bad;
      model(m, e_inv, e_sing, e_ovf, kab);
      e_cyc = (kab < 0) ? N*(N+1) + 3 : kab*(N+1) + 4;
      @(negedge clk);
      A = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; ndone = 0; busy_bad = 0; snap_cyc = -1;
      for (int c = 1; c <= e_cyc + 3; c++) begin
         start = (c == restart_cyc);
         if (done === 1'b1) begin
            ndone++;
            if (snap_cyc < 0) begin
               snap_cyc = c; snap_inv = A_inv; snap_sing = singular; snap_ovf = overflow;
            end
         end
         if (busy !== (c < e_cyc)) busy_bad++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check_eq({tag, "_done_cyc"}, 64'(snap_cyc), 64'(e_cyc));
      check_eq({tag, "_ndone"}, 64'(ndone), 64'd1);
      check_eq({tag, "_busy_bad"}, 64'(busy_bad), 64'd0);
      check_eq({tag, "_singular"}, 64'(snap_sing), 64'(e_sing));
      check_eq({tag, "_overflow"}, 64'(snap_ovf), 64'(e_ovf));
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            check_eq($sformatf("%s_inv%0d%0d", tag, i, j), 64'(snap_inv[i][j]), 64'(e_inv[i][j]));
   endtask

   task automatic reset_mid(input mat_t m, input int rst_cyc);
      int ndone;
      ndone = 0;
      @(negedge clk);
      A = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < rst_cyc; c++) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_busy", 64'(busy), 64'd0);
      check_eq("rst_mid_done", 64'(done), 64'd0);
      check_eq("rst_mid_singular", 64'(singular), 64'd0);
      check_eq("rst_mid_inv_zero", 64'(A_inv == '0), 64'd1);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0) ndone++;
      end
      check_eq("rst_mid_no_done", 64'(ndone), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic mat_t gen_rand(input int mode);
      mat_t m;
      int   v;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            case (mode)
               0: begin
                  if (i == j) begin
                     v = 196608 + int'($urandom_range(0, 65535));
                     if ($urandom_range(0, 1) == 1) v = -v;
                  end else v = int'($urandom_range(0, 131072)) - 65536;
               end
               1:       v = int'($urandom_range(0, 262144)) - 131072;
               default: v = int'($urandom_range(0, 6)) - 3;
            endcase
            m[i][j] = DATA_W'(v);
         end
      return m;
   endfunction

   initial begin
      mat_t m;
      @(posedge clk); #1;
      check_eq("reset_busy", 64'(busy), 64'd0);
      check_eq("reset_done", 64'(done), 64'd0);
      check_eq("reset_singular", 64'(singular), 64'd0);
      check_eq("reset_overflow", 64'(overflow), 64'd0);
      check_eq("reset_inv_zero", 64'(A_inv == '0), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      m = '0;
      for (int i = 0; i < N; i++) m[i][i] = 32'h0001_0000;
      run(m, "ident", 0);
      check_eq("ident_diag_const", 64'(snap_inv[2][2]), 64'h0001_0000);
      check_eq("ident_off_const", 64'(snap_inv[0][3]), 64'h0);
      check_eq("ident_cyc_const", 64'(snap_cyc), 64'd23);

      m = '0;
      m[0][0] = 32'h0002_0000; m[1][1] = 32'h0004_0000; m[2][2] = 32'h0000_8000; m[3][3] = 32'h0001_0000;
      run(m, "diag", 0);
      check_eq("diag_d0_const", 64'(snap_inv[0][0]), 64'h0000_8000);
      check_eq("diag_d1_const", 64'(snap_inv[1][1]), 64'h0000_4000);
      check_eq("diag_d2_const", 64'(snap_inv[2][2]), 64'h0002_0000);
      check_eq("diag_d3_const", 64'(snap_inv[3][3]), 64'h0001_0000);

      m = '0;
      for (int i = 0; i < N; i++) m[i][N-1-i] = 32'h0001_0000;
      run(m, "anti", 0);
      check_eq("anti_self_inverse", 64'(snap_inv == m), 64'd1);

      m = '0;
      run(m, "zero", 0);
      check_eq("zero_cyc_const", 64'(snap_cyc), 64'd4);
      check_eq("zero_sing_const", 64'(snap_sing), 64'd1);

      m = '0;
      for (int i = 0; i < N; i++) m[i][i] = 32'h0001_0000;
      m[2] = m[1];
      run(m, "duprow", 0);
      check_eq("duprow_sing_const", 64'(snap_sing), 64'd1);

      m = '0;
      m[0][0] = 32'h0000_0002; m[1][1] = 32'h0001_0000; m[2][2] = 32'h0001_0000; m[3][3] = 32'h0001_0000;
      run(m, "sat", 0);
      check_eq("sat_d0_const", 64'(snap_inv[0][0]), 64'h7FFF_FFFF);
      check_eq("sat_d1_const", 64'(snap_inv[1][1]), 64'h0001_0000);
      check_eq("sat_ovf_const", 64'(snap_ovf), 64'd1);

      run(gen_rand(0), "restart10", 10);
      run(gen_rand(0), "start_at_done", 23);

      reset_mid(gen_rand(0), 12);
      run(gen_rand(0), "post_rst", 0);
      check_eq("post_rst_cyc_const", 64'(snap_cyc), 64'd23);

      for (int t = 0; t < 12; t++) run(gen_rand(t % 3), $sformatf("rnd%0d", t), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
